// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op encodings, sequencer states and operand-sign helpers for md_seq_unit
package md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// rtl/md_iter_step.sv - one combinational shift-add (mul) or restoring shift-subtract (div) step
module md_iter_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              mbit_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Mul: {hi,lo} holds the partial product and shifts right each step.
  // Div: {rem,quo} shifts left; a clear borrow bit means the subtract is kept.
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (mbit_i ? opnd_i : {XLEN{1'b0}})};
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/md_seq_unit.sv
// rtl/md_seq_unit.sv - iterative RV32M multiply/divide unit with stall/done sequencer
// MD_SEQ_EARLY_OUT_EN: divide-by-zero and signed-overflow divides finish from PREP.
module md_seq_unit
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, opnd;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, special, fix_val;
  logic              div_zero, div_ovf, div_special;

  always_comb begin
    a_neg = a_signed(op_q) & a_q[XLEN-1];
    b_neg = b_signed(op_q) & b_q[XLEN-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    opnd  = is_div(op_q) ? b_mag : a_mag;
  end

  md_iter_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd),
    .mbit_i   (b_mag[cnt_q]),
    .acc_o    (acc_step)
  );

  // Special divide cases override the iterated result regardless of the build.
  always_comb begin
    div_zero    = (b_q == {XLEN{1'b0}});
    div_ovf     = b_signed(op_q) & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == {XLEN{1'b1}});
    div_special = is_div(op_q) & (div_zero | div_ovf);
    if (!op_q[1]) begin
      special = div_zero ? {XLEN{1'b1}} : a_q;
    end else begin
      special = div_zero ? a_q : {XLEN{1'b0}};
    end
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:               fix_val = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU,
      MD_MULHU:             fix_val = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:      fix_val = quo;
      default:              fix_val = rem;
    endcase
    if (div_special) begin
      fix_val = special;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    busy_o   = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          stall_o = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        stall_o = 1'b1;
        sa_d    = a_neg;
        sb_d    = b_neg;
        acc_d   = is_div(op_q) ? {{XLEN{1'b0}}, a_mag} : {(2*XLEN){1'b0}};
        cnt_d   = '0;
        state_d = S_RUN;
`ifdef MD_SEQ_EARLY_OUT_EN
        if (div_special) begin
          result_d = special;
          state_d  = S_DONE;
        end
`endif
        if (flush_i) begin
          result_d = result_q;
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        stall_o = 1'b1;
        acc_d   = acc_step;
        if (cnt_q == CW'(XLEN-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (flush_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_FIX: begin
        stall_o  = 1'b1;
        result_d = fix_val;
        state_d  = S_DONE;
        if (flush_i) begin
          result_d = result_q;
          state_d  = S_IDLE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_md_seq_unit.sv
// tb/tb_md_seq_unit.sv - directed vector bench for md_seq_unit
module tb_md_seq_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  md_seq_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .flush_i  (flush),
    .stall_o  (stall),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MD_SEQ_EARLY_OUT_EN
    if (o[2] && ((y == 32'h0) || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)))
      return 2;
`endif
    return 35;
  endfunction

  // Called at a negedge in an IDLE cycle; returns at the negedge of the cycle after done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int glitch_k, input string nm);
    int k;
    logic stall_bad;
    op = o; a = x; b = y; start = 1'b1;
    #1 chk({31'd0, stall}, 32'd1, {nm, " stall_accept"});
    @(negedge clk);
    start = 1'b0;
    k = 1;
    stall_bad = 1'b0;
    while (!done && k < 100) begin
      if (!stall) stall_bad = 1'b1;
      if (k == glitch_k) begin
        start = 1'b1; op = 3'b101; a = 32'd1; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk(k, exp_lat(o, x, y), {nm, " latency"});
    chk(result, exp, {nm, " result"});
    chk({31'd0, stall}, 32'd0, {nm, " stall_at_done"});
    chk({31'd0, stall_bad}, 32'd0, {nm, " stall_gap"});
    @(negedge clk);
    chk({31'd0, done}, 32'd0, {nm, " done_width"});
    chk({31'd0, busy}, 32'd0, {nm, " idle_after"});
  endtask

  initial begin
    int k;
    logic seen_done;
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[5]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[6]  = '{3'b101, 32'd100,      32'd0,        32'hFFFFFFFF};
    vecs[7]  = '{3'b111, 32'd100,      32'd0,        32'd100};
    vecs[8]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[9]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[10] = '{3'b000, 32'h12345678, 32'h10,       32'h23456780};
    vecs[11] = '{3'b101, 32'hFFFFFFFF, 32'd3,        32'h55555555};
    vecs[12] = '{3'b111, 32'd100,      32'd7,        32'd2};
    vecs[13] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[14] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
    vecs[15] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
    vecs[16] = '{3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD};
    vecs[17] = '{3'b110, 32'd20,       32'hFFFFFFFA, 32'd2};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk({31'd0, done}, 32'd0, "reset done");
    chk({31'd0, busy}, 32'd0, "reset busy");
    chk({31'd0, stall}, 32'd0, "reset stall");
    chk(result, 32'd0, "reset result");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("v%0d", i));
    end

    run_op(3'b000, 32'd3, 32'd5, 32'd15, 5, "start_mid_run");

    // Flush in RUN with counter at 10: prior result (15) must survive.
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k < 12; k++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk({31'd0, busy}, 32'd0, "flush busy");
    chk({31'd0, stall}, 32'd0, "flush stall");
    chk(result, 32'd15, "flush result");
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk({31'd0, seen_done}, 32'd0, "flush no_done");

    run_op(3'b011, 32'h80000000, 32'd2, 32'd1, 0, "after_flush");

    // Flush together with start in IDLE drops the start.
    op = 3'b000; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    #1 chk({31'd0, stall}, 32'd0, "flush_start stall");
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk({31'd0, busy}, 32'd0, "flush_start busy");
    chk(result, 32'd1, "flush_start result");

    // Reset with RUN counter at 5.
    op = 3'b101; a = 32'd1000; b = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k < 7; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({31'd0, done}, 32'd0, "midrst done");
    chk({31'd0, busy}, 32'd0, "midrst busy");
    chk({31'd0, stall}, 32'd0, "midrst stall");
    chk(result, 32'd0, "midrst result");
    rst = 1'b0;
    @(negedge clk);

    run_op(3'b101, 32'd1000, 32'd10, 32'd100, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
